// File: rtl/pipe_skid_reg.sv
// ============================================================================
// pipe_skid_reg: valid/ready pipeline stage with optional 2-entry skid buffer,
// synchronous flush and a saturating backpressure counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 8,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_count
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    bp_count_q, bp_count_d;
  logic                in_fire;
  logic                out_fire;

  generate
    if (SKID_EN != 0) begin : g_skid_ready
      // Registered-only ready: no path from out_ready back to in_ready.
      assign in_ready = (state_q != FULL) && !flush;
    end else begin : g_comb_ready
      assign in_ready = (!out_valid || out_ready) && !flush;
    end
  endgenerate

  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign bp_count  = bp_count_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    bp_count_d = bp_count_q;
    if (out_valid && !out_ready && (bp_count_q != {CNT_W{1'b1}})) begin
      bp_count_d = bp_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      bp_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      bp_count_q  <= bp_count_d;
    end
  end

  // Control is masked at the output, so these need no reset.
  always_ff @(posedge clk) begin
    main_ctrl_q <= main_ctrl_d;
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// tb_pipe_skid_reg: directed table-driven bench for pipe_skid_reg (skid and
// non-skid builds). Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_ready;

  logic        ir1, ov1;
  logic [7:0]  oc1;
  logic [63:0] od1;
  logic [1:0]  occ1;
  logic [3:0]  bp1;

  logic        ir0, ov0;
  logic [7:0]  oc0;
  logic [63:0] od0;
  logic [1:0]  occ0;
  logic [15:0] bp0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(64), .CTRL_W(8), .SKID_EN(1), .CNT_W(4)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1), .bp_count(bp1)
  );

  pipe_skid_reg #(.DATA_W(64), .CTRL_W(8), .SKID_EN(0), .CNT_W(16)) dut_flat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0), .bp_count(bp0)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic [7:0] ic;
    logic       ordy;
    logic       eov;
    logic [7:0] eod;
    logic [7:0] eoc;
    logic [1:0] eocc;
    logic       eir;
    logic [3:0] ebp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic iv, input logic [7:0] id,
                     input logic [7:0] ic, input logic ordy, input logic eov,
                     input logic [7:0] eod, input logic [7:0] eoc,
                     input logic [1:0] eocc, input logic eir, input logic [3:0] ebp);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eoc = eoc; v.eocc = eocc; v.eir = eir; v.ebp = ebp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then let them settle.
  task automatic drive(input logic fl, input logic iv, input logic [7:0] id,
                       input logic [7:0] ic, input logic ordy);
    @(negedge clk);
    flush = fl; in_valid = iv; in_data = {56'd0, id}; in_ctrl = ic; out_ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    //  fl iv  id     ic     or  eov eod    eoc    occ ir bp
    // streaming 0x10..0x17
    add(0, 1, 8'h10, 8'h01, 1,  0, 8'h00, 8'h00, 0,  1, 0);
    for (int i = 1; i < 8; i++)
      add(0, 1, 8'(8'h10 + i), 8'(i + 1), 1, 1, 8'(8'h0F + i), 8'(i), 1, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1,  1, 8'h17, 8'h08, 1,  1, 0);
    add(0, 0, 8'h00, 8'h00, 1,  0, 8'h17, 8'h00, 0,  1, 0);
    // backpressure 0xA1..0xA3
    add(0, 1, 8'hA1, 8'h11, 0,  0, 8'h17, 8'h00, 0,  1, 0);
    add(0, 1, 8'hA2, 8'h12, 0,  1, 8'hA1, 8'h11, 1,  1, 0);
    add(0, 1, 8'hA3, 8'h13, 0,  1, 8'hA1, 8'h11, 2,  0, 1);
    add(0, 1, 8'hA3, 8'h13, 0,  1, 8'hA1, 8'h11, 2,  0, 2);
    add(0, 1, 8'hA3, 8'h13, 1,  1, 8'hA1, 8'h11, 2,  0, 3);
    add(0, 1, 8'hA3, 8'h13, 1,  1, 8'hA2, 8'h12, 1,  1, 3);
    add(0, 0, 8'h00, 8'h00, 1,  1, 8'hA3, 8'h13, 1,  1, 3);
    add(0, 0, 8'h00, 8'h00, 0,  0, 8'hA3, 8'h00, 0,  1, 3);
    // flush while FULL with 0xB0 offered
    add(0, 1, 8'hC1, 8'h21, 0,  0, 8'hA3, 8'h00, 0,  1, 3);
    add(0, 1, 8'hC2, 8'h22, 0,  1, 8'hC1, 8'h21, 1,  1, 3);
    add(1, 1, 8'hB0, 8'h30, 0,  1, 8'hC1, 8'h21, 2,  0, 4);
    add(0, 0, 8'h00, 8'h00, 1,  0, 8'hC1, 8'h00, 0,  1, 5);
    add(0, 0, 8'h00, 8'h00, 1,  0, 8'hC1, 8'h00, 0,  1, 5);
    // ctrl masking
    add(0, 1, 8'hD0, 8'hFF, 1,  0, 8'hC1, 8'h00, 0,  1, 5);
    add(0, 0, 8'h00, 8'h00, 1,  1, 8'hD0, 8'hFF, 1,  1, 5);
    add(0, 0, 8'h00, 8'h00, 1,  0, 8'hD0, 8'h00, 0,  1, 5);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy);
      chk($sformatf("v%0d out_valid", i), 64'(ov1), 64'(vecs[i].eov));
      chk($sformatf("v%0d out_data", i), od1, {56'd0, vecs[i].eod});
      chk($sformatf("v%0d out_ctrl", i), 64'(oc1), 64'(vecs[i].eoc));
      chk($sformatf("v%0d occupancy", i), 64'(occ1), 64'(vecs[i].eocc));
      chk($sformatf("v%0d in_ready", i), 64'(ir1), 64'(vecs[i].eir));
      chk($sformatf("v%0d bp_count", i), 64'(bp1), 64'(vecs[i].ebp));
    end

    // Fill to FULL, then stall long enough to saturate the 4-bit counter.
    drive(0, 1, 8'hE1, 8'h41, 0);
    drive(0, 1, 8'hE2, 8'h42, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, 8'h00, 8'h00, 0);
    chk("sat bp_count", 64'(bp1), 64'd15);
    chk("sat occupancy", 64'(occ1), 64'd2);
    drive(0, 0, 8'h00, 8'h00, 0);
    chk("sat hold", 64'(bp1), 64'd15);
    chk("sat out_data", od1, 64'hE1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("rst out_valid", 64'(ov1), 64'd0);
    chk("rst out_ctrl", 64'(oc1), 64'd0);
    chk("rst out_data", od1, 64'd0);
    chk("rst occupancy", 64'(occ1), 64'd0);
    chk("rst bp_count", 64'(bp1), 64'd0);
    chk("rst in_ready", 64'(ir1), 64'd1);
    #1 rst = 1'b0;

    // Non-skid build: combinational ready and single-cycle replacement.
    drive(0, 1, 8'h55, 8'h05, 0);
    chk("flat empty in_ready", 64'(ir0), 64'd1);
    drive(0, 1, 8'h66, 8'h06, 0);
    chk("flat stall in_ready", 64'(ir0), 64'd0);
    chk("flat held data", od0, 64'h55);
    chk("flat bp_count", 64'(bp0), 64'd0);
    drive(0, 1, 8'h66, 8'h06, 1);
    chk("flat ready follows out_ready", 64'(ir0), 64'd1);
    chk("flat still 55", od0, 64'h55);
    drive(0, 1, 8'h77, 8'h07, 1);
    chk("flat replaced 66", od0, 64'h66);
    chk("flat ctrl 06", 64'(oc0), 64'h06);
    chk("flat occupancy", 64'(occ0), 64'd1);
    chk("flat bp after stall", 64'(bp0), 64'd1);
    drive(0, 0, 8'h00, 8'h00, 1);
    chk("flat replaced 77", od0, 64'h77);
    drive(0, 0, 8'h00, 8'h00, 1);
    chk("flat drained", 64'(ov0), 64'd0);
    chk("flat drained ctrl", 64'(oc0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
